store_merge: RTL and testbench

Store-side byte/halfword merge engine for the multicycle datapath. It is the write-path counterpart of the load-halfword/extend path. For `sb`/`sh`, it reads the aligned memory word, splices the low byte or halfword of the store operand into the lane selected by the address, and writes the word back. For `sw`, it writes straight through. It sits between the B register / ALUOut and the memory port, and is sequenced by the control unit through a start/done handshake.

---
 rtl/store_merge.sv | 162 ++++++++++++++++
 tb/tb_store_merge.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
// Store-side byte/halfword merge engine for the multicycle datapath.
// sb/sh: read the aligned memory word, splice the low byte/half of the store
// operand into the addressed lane (little-endian), write the word back.
// sw: write straight through without a read.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-low
//   start       request pulse, sampled only in IDLE
//   ssControl   store size: 00 word, 01 half, 10 byte, 11 illegal
//   addr        byte address
//   storeData   store operand
//   memDataIn   memory read data (valid MEM_LATENCY cycles after memAddr)
//   memAddr     word-aligned memory address
//   memWr       memory write enable (WRITE state only)
//   memDataOut  memory write data, holds between writes
//   busy        high in READ and WRITE
//   done        one-cycle completion pulse
//   err         misalignment / illegal size, valid with done
// -----------------------------------------------------------------------------
module store_merge #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ssControl,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    input  logic [31:0] memDataIn,
    output logic [31:0] memAddr,
    output logic        memWr,
    output logic [31:0] memDataOut,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    localparam logic [1:0] SizeWord = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeByte = 2'b10;
    localparam logic [2:0] LatCnt   = 3'(MEM_LATENCY);

    state_e      r_state;
    logic [2:0]  r_cnt;
    logic [1:0]  r_lane;   // captured addr[1:0]; upper bits live in memAddr
    logic [15:0] r_data;   // only the low half of the operand is ever merged
    logic [1:0]  r_size;

    logic        w_legal;
    logic [31:0] w_merged;

    // Legality of the request presented on the inputs at the capture edge.
    always_comb begin
        w_legal = 1'b0;
        case (ssControl)
            SizeWord: w_legal = (addr[1:0] == 2'b00);
            SizeHalf: w_legal = ~addr[0];
            SizeByte: w_legal = 1'b1;
            default:  w_legal = 1'b0;
        endcase
    end

    // Splice captured operand into the word currently on memDataIn.
    always_comb begin
        w_merged = memDataIn;
        if (r_size == SizeByte) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_data;
        end else begin
            w_merged[15:0] = r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_lane     <= 2'd0;
            r_data     <= 16'd0;
            r_size     <= 2'd0;
            memAddr    <= 32'd0;
            memWr      <= 1'b0;
            memDataOut <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        r_lane <= addr[1:0];
                        r_data <= storeData[15:0];
                        r_size <= ssControl;
                        if (!w_legal) begin
                            // No memory access for a rejected request.
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            memAddr <= {addr[31:2], 2'b00};
                            if (ssControl == SizeWord) begin
                                memWr      <= 1'b1;
                                memDataOut <= storeData;
                                r_state    <= StWrite;
                            end else begin
                                r_cnt   <= LatCnt;
                                r_state <= StRead;
                            end
                        end
                    end
                end

                StRead: begin
                    if (r_cnt == 3'd0) begin
                        // Last READ cycle: memDataIn is valid now.
                        memDataOut <= w_merged;
                        memWr      <= 1'b1;
                        r_state    <= StWrite;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                StWrite: begin
                    memWr   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= StDone;
                end

                StDone: begin
                    done    <= 1'b0;
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge.sv
// -----------------------------------------------------------------------------
// tb_store_merge
// Directed bench for store_merge. Three instances (MEM_LATENCY 0, 1, 3) share
// the stimulus; each has its own memory read pipeline of matching depth.
// Memory is read-only: word 0x100 = 0xAABBCCDD, everything else 0.
// -----------------------------------------------------------------------------
module tb_store_merge;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  ss;
    logic [31:0] addr;
    logic [31:0] sd;

    logic [31:0] md0, md1, md3;
    logic [31:0] ma0, ma1, ma3;
    logic [31:0] mo0, mo1, mo3;
    logic        wr0, wr1, wr3;
    logic        bz0, bz1, bz3;
    logic        dn0, dn1, dn3;
    logic        er0, er1, er3;

    logic [31:0] p1_q;
    logic [31:0] p3_q [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hAABB_CCDD : 32'h0;
    endfunction

    // Read pipelines: data valid MEM_LATENCY cycles after the address.
    assign md0 = rd(ma0);
    always_ff @(posedge clk) begin
        p1_q    <= rd(ma1);
        p3_q[0] <= rd(ma3);
        p3_q[1] <= p3_q[0];
        p3_q[2] <= p3_q[1];
    end
    assign md1 = p1_q;
    assign md3 = p3_q[2];

    store_merge #(.MEM_LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .ssControl(ss), .addr(addr),
        .storeData(sd), .memDataIn(md0), .memAddr(ma0), .memWr(wr0),
        .memDataOut(mo0), .busy(bz0), .done(dn0), .err(er0)
    );

    store_merge #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .ssControl(ss), .addr(addr),
        .storeData(sd), .memDataIn(md1), .memAddr(ma1), .memWr(wr1),
        .memDataOut(mo1), .busy(bz1), .done(dn1), .err(er1)
    );

    store_merge #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .ssControl(ss), .addr(addr),
        .storeData(sd), .memDataIn(md3), .memAddr(ma3), .memWr(wr3),
        .memDataOut(mo3), .busy(bz3), .done(dn3), .err(er3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sb/sh on the default-latency instance: two READ cycles, WRITE, DONE.
    task automatic run_merge(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s, input logic [31:0] exp);
        start = 1'b1; addr = a; sd = d; ss = s;
        step();
        start = 1'b0;
        chk({tag, ".rd1_busy"}, 32'(bz1), 32'd1);
        chk({tag, ".rd1_wr"}, 32'(wr1), 32'd0);
        chk({tag, ".rd1_addr"}, ma1, {a[31:2], 2'b00});
        step();
        chk({tag, ".rd2_wr"}, 32'(wr1), 32'd0);
        step();
        chk({tag, ".wr_en"}, 32'(wr1), 32'd1);
        chk({tag, ".wr_addr"}, ma1, {a[31:2], 2'b00});
        chk({tag, ".wr_data"}, mo1, exp);
        step();
        chk({tag, ".done"}, 32'(dn1), 32'd1);
        chk({tag, ".err"}, 32'(er1), 32'd0);
        chk({tag, ".done_busy"}, 32'(bz1), 32'd0);
        chk({tag, ".done_wr"}, 32'(wr1), 32'd0);
        step();
        chk({tag, ".idle_done"}, 32'(dn1), 32'd0);
    endtask

    // Illegal request: done/err one cycle after start, no write.
    task automatic run_illegal(input string tag, input logic [31:0] a, input logic [1:0] s);
        start = 1'b1; addr = a; sd = 32'h5555_5555; ss = s;
        step();
        start = 1'b0;
        chk({tag, ".done"}, 32'(dn1), 32'd1);
        chk({tag, ".err"}, 32'(er1), 32'd1);
        chk({tag, ".wr"}, 32'(wr1), 32'd0);
        chk({tag, ".busy"}, 32'(bz1), 32'd0);
        step();
        chk({tag, ".after_done"}, 32'(dn1), 32'd0);
        chk({tag, ".after_wr"}, 32'(wr1), 32'd0);
    endtask

    initial begin
        int          rc0, rc1, rc3;
        int          dc0, dc1, dc3;
        logic [31:0] w0, w1, w3;
        int          bad_wr, bad_done;

        reset = 1'b0; start = 1'b0; ss = 2'b00; addr = 32'h0; sd = 32'h0;
        step();
        step();
        chk("rst.busy", 32'(bz1), 32'd0);
        chk("rst.done", 32'(dn1), 32'd0);
        chk("rst.err", 32'(er1), 32'd0);
        chk("rst.wr", 32'(wr1), 32'd0);
        chk("rst.addr", ma1, 32'h0);
        chk("rst.data", mo1, 32'h0);
        reset = 1'b1;
        step();

        // Latency sweep: same sb on all three instances, count READ cycles.
        rc0 = 0; rc1 = 0; rc3 = 0; dc0 = 0; dc1 = 0; dc3 = 0;
        w0 = 32'h0; w1 = 32'h0; w3 = 32'h0;
        start = 1'b1; addr = 32'h101; sd = 32'h1234_5677; ss = 2'b10;
        step();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bz0 && !wr0) rc0++;
            if (bz1 && !wr1) rc1++;
            if (bz3 && !wr3) rc3++;
            if (wr0) w0 = mo0;
            if (wr1) w1 = mo1;
            if (wr3) w3 = mo3;
            if (dn0) dc0++;
            if (dn1) dc1++;
            if (dn3) dc3++;
            step();
        end
        chk("lat0.reads", 32'(rc0), 32'd1);
        chk("lat1.reads", 32'(rc1), 32'd2);
        chk("lat3.reads", 32'(rc3), 32'd4);
        chk("lat0.data", w0, 32'hAABB_77DD);
        chk("lat1.data", w1, 32'hAABB_77DD);
        chk("lat3.data", w3, 32'hAABB_77DD);
        chk("lat0.dones", 32'(dc0), 32'd1);
        chk("lat1.dones", 32'(dc1), 32'd1);
        chk("lat3.dones", 32'(dc3), 32'd1);

        // Directed merges on the default-latency instance.
        run_merge("sb101", 32'h101, 32'h1234_5677, 2'b10, 32'hAABB_77DD);
        run_merge("sb103", 32'h103, 32'h0000_0011, 2'b10, 32'h11BB_CCDD);
        run_merge("sh_hi", 32'h102, 32'h0000_BEEF, 2'b01, 32'hBEEF_CCDD);
        run_merge("sh_lo", 32'h100, 32'h0000_BEEF, 2'b01, 32'hAABB_BEEF);

        // sw: write in the cycle after start, done the cycle after that.
        start = 1'b1; addr = 32'h104; sd = 32'hCAFE_F00D; ss = 2'b00;
        step();
        start = 1'b0;
        chk("sw.wr", 32'(wr1), 32'd1);
        chk("sw.addr", ma1, 32'h104);
        chk("sw.data", mo1, 32'hCAFE_F00D);
        step();
        chk("sw.done", 32'(dn1), 32'd1);
        chk("sw.err", 32'(er1), 32'd0);
        chk("sw.done_wr", 32'(wr1), 32'd0);
        chk("sw.hold_data", mo1, 32'hCAFE_F00D);
        step();

        run_illegal("ill_sh103", 32'h103, 2'b01);
        run_illegal("ill_sw106", 32'h106, 2'b00);
        run_illegal("ill_ss11", 32'h100, 2'b11);

        // Start held high through READ/WRITE/DONE with different request.
        start = 1'b1; addr = 32'h101; sd = 32'h1234_5677; ss = 2'b10;
        step();
        addr = 32'h102; sd = 32'hFFFF_0000; ss = 2'b01;
        chk("busy_ign.err_cleared", 32'(er1), 32'd0);
        step();
        step();
        chk("busy_ign.wr", 32'(wr1), 32'd1);
        chk("busy_ign.data", mo1, 32'hAABB_77DD);
        step();
        chk("busy_ign.done", 32'(dn1), 32'd1);
        step();
        start = 1'b0;
        chk("busy_ign.idle_busy", 32'(bz1), 32'd0);
        step();
        chk("busy_ign.not_queued", 32'(bz1), 32'd0);
        chk("busy_ign.no_wr", 32'(wr1), 32'd0);

        // Reset during the second READ cycle of an sb.
        start = 1'b1; addr = 32'h101; sd = 32'h1234_5677; ss = 2'b10;
        step();
        start = 1'b0;
        step();
        chk("rst_mid.in_read", 32'(bz1), 32'd1);
        reset = 1'b0;
        step();
        chk("rst_mid.busy", 32'(bz1), 32'd0);
        chk("rst_mid.wr", 32'(wr1), 32'd0);
        chk("rst_mid.done", 32'(dn1), 32'd0);
        chk("rst_mid.addr", ma1, 32'h0);
        chk("rst_mid.data", mo1, 32'h0);
        reset = 1'b1;
        bad_wr = 0; bad_done = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (wr1) bad_wr++;
            if (dn1) bad_done++;
        end
        chk("rst_mid.no_write", 32'(bad_wr), 32'd0);
        chk("rst_mid.no_done", 32'(bad_done), 32'd0);

        start = 1'b1; addr = 32'h104; sd = 32'h0BAD_F00D; ss = 2'b00;
        step();
        start = 1'b0;
        chk("post_rst_sw.wr", 32'(wr1), 32'd1);
        chk("post_rst_sw.addr", ma1, 32'h104);
        chk("post_rst_sw.data", mo1, 32'h0BAD_F00D);
        step();
        chk("post_rst_sw.done", 32'(dn1), 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
